ps2_frame_rx: RTL and testbench

PS/2 keyboard receive front end that feeds the key/opcode decoding stage of the VGA character display.
- Synchronises and glitch-filters the raw ps2Clk/ps2Data pins.
- Deserialises 11-bit device-to-host frames and checks parity, start and stop.
- Folds F0 (break) and E0 (extended) prefix bytes into per-key flags.
- Presents one clean scan-code event per key action as a single-cycle strobe, in the pixel clock domain.

---
 rtl/ps2_pkg.sv | 24 ++
 rtl/ps2_sync_filter.sv | 52 +++++
 rtl/ps2_frame_rx.sv | 158 +++++++++++++++
 tb/tb_ps2_frame_rx.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive front end.
package ps2_pkg;

  // Frame deserialiser states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  // Prefix bytes folded into per-key flags instead of being reported.
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  localparam int FILTER_LEN_DEF     = 4;
  localparam int TIMEOUT_CYCLES_DEF = 50000;

  // PS/2 uses odd parity: data bits plus parity bit hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// ps2Clk conditioning: two-flop synchroniser, level filter, falling-edge pulse.
module ps2_sync_filter
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = FILTER_LEN_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic ps2Clk,
  output logic fall
);

  logic [1:0] sync_q;
  logic       filt_q, filt_d;
  logic [3:0] cnt_q, cnt_d;
  logic       fall_q, fall_d;
  logic       s;

  assign s    = sync_q[1];
  assign fall = fall_q;

  // Filtered level moves only after FILTER_LEN consecutive samples disagree with it.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = 4'd0;
    fall_d = 1'b0;
    if (s != filt_q) begin
      if (cnt_q == 4'(FILTER_LEN - 1)) begin
        filt_d = s;
        fall_d = ~s;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  // Synchroniser and filter state; idle bus level is high.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q <= 2'b11;
      filt_q <= 1'b1;
      cnt_q  <= 4'd0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], ps2Clk};
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
      fall_q <= fall_d;
    end
  end

endmodule

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver with break/extended prefix folding.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = FILTER_LEN_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2Clk,
  input  logic       ps2Data,
  output logic [7:0] scanCode,
  output logic       keyValid,
  output logic       keyBreak,
  output logic       keyExt,
  output logic       frameErr
);

  logic        fall;
  logic [1:0]  dsync_q;
  logic        din;

  ps2_state_e  state_q, state_d;
  logic [2:0]  bitCnt_q, bitCnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        par_q, par_d;
  logic [15:0] to_q, to_d;
  logic        breakPend_q, breakPend_d;
  logic        extPend_q, extPend_d;
  logic [7:0]  code_q, code_d;
  logic        brk_q, brk_d;
  logic        ext_q, ext_d;
  logic        kv_q, kv_d;
  logic        fe_q, fe_d;
  logic        timeout;

  ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clock  (clock),
    .reset  (reset),
    .ps2Clk (ps2Clk),
    .fall   (fall)
  );

  assign din      = dsync_q[1];
  assign scanCode = code_q;
  assign keyValid = kv_q;
  assign keyBreak = brk_q;
  assign keyExt   = ext_q;
  assign frameErr = fe_q;

  // A sample event in the timeout cycle wins, so timeout is gated by fall.
  assign timeout = (state_q != ST_IDLE) && !fall &&
                   (to_q == 16'(TIMEOUT_CYCLES - 1));

  // Frame FSM, prefix folding and output strobes.
  always_comb begin
    state_d     = state_q;
    bitCnt_d    = bitCnt_q;
    shift_d     = shift_q;
    par_d       = par_q;
    breakPend_d = breakPend_q;
    extPend_d   = extPend_q;
    code_d      = code_q;
    brk_d       = brk_q;
    ext_d       = ext_q;
    kv_d        = 1'b0;
    fe_d        = 1'b0;
    to_d        = (state_q == ST_IDLE || fall) ? 16'd0 : to_q + 16'd1;

    case (state_q)
      ST_IDLE: begin
        if (fall && !din) begin
          state_d  = ST_DATA;
          bitCnt_d = 3'd0;
        end
      end
      ST_DATA: begin
        if (fall) begin
          shift_d  = {din, shift_q[7:1]};
          bitCnt_d = bitCnt_q + 3'd1;
          if (bitCnt_q == 3'd7) state_d = ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (fall) begin
          par_d   = din;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (fall) begin
          state_d = ST_IDLE;
          if (din && odd_parity_ok(shift_q, par_q)) begin
            if (shift_q == SC_BREAK) begin
              breakPend_d = 1'b1;
            end else if (shift_q == SC_EXT) begin
              extPend_d = 1'b1;
            end else begin
              code_d      = shift_q;
              brk_d       = breakPend_q;
              ext_d       = extPend_q;
              kv_d        = 1'b1;
              breakPend_d = 1'b0;
              extPend_d   = 1'b0;
            end
          end else begin
            fe_d        = 1'b1;
            breakPend_d = 1'b0;
            extPend_d   = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A stalled frame is abandoned; any half-collected prefix goes with it.
    if (timeout) begin
      state_d     = ST_IDLE;
      fe_d        = 1'b1;
      breakPend_d = 1'b0;
      extPend_d   = 1'b0;
    end
  end

  // Data pin synchroniser and all receiver state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dsync_q     <= 2'b11;
      state_q     <= ST_IDLE;
      bitCnt_q    <= 3'd0;
      shift_q     <= 8'd0;
      par_q       <= 1'b0;
      to_q        <= 16'd0;
      breakPend_q <= 1'b0;
      extPend_q   <= 1'b0;
      code_q      <= 8'd0;
      brk_q       <= 1'b0;
      ext_q       <= 1'b0;
      kv_q        <= 1'b0;
      fe_q        <= 1'b0;
    end else begin
      dsync_q     <= {dsync_q[0], ps2Data};
      state_q     <= state_d;
      bitCnt_q    <= bitCnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      to_q        <= to_d;
      breakPend_q <= breakPend_d;
      extPend_q   <= extPend_d;
      code_q      <= code_d;
      brk_q       <= brk_d;
      ext_q       <= ext_d;
      kv_q        <= kv_d;
      fe_q        <= fe_d;
    end
  end

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Directed bench for ps2_frame_rx: frame table plus timeout, glitch and reset sequences.
module tb_ps2_frame_rx;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic c1 = 1'b1, d1 = 1'b1;
  logic c2 = 1'b1, d2 = 1'b1;

  logic [7:0] sc1, sc2;
  logic kv1, kb1, ke1, fe1;
  logic kv2, kb2, ke2, fe2;

  always #5 clock = ~clock;

  // Default timing: used for the frame table, glitch and reset checks.
  ps2_frame_rx #(.FILTER_LEN(4), .TIMEOUT_CYCLES(50000)) dut (
    .clock(clock), .reset(reset), .ps2Clk(c1), .ps2Data(d1),
    .scanCode(sc1), .keyValid(kv1), .keyBreak(kb1), .keyExt(ke1), .frameErr(fe1)
  );

  // Short timeout instance on its own pins.
  ps2_frame_rx #(.FILTER_LEN(4), .TIMEOUT_CYCLES(500)) dut_to (
    .clock(clock), .reset(reset), .ps2Clk(c2), .ps2Data(d2),
    .scanCode(sc2), .keyValid(kv2), .keyBreak(kb2), .keyExt(ke2), .frameErr(fe2)
  );

  int kvc1 = 0, fec1 = 0, both1 = 0;
  int kvc2 = 0, fec2 = 0;
  int nvec = 0, nerr = 0;

  // Strobe counters.
  always @(negedge clock) begin
    if (kv1) kvc1++;
    if (fe1) fec1++;
    if (kv1 && fe1) both1++;
    if (kv2) kvc2++;
    if (fe2) fec2++;
  end

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // {stop, parity, data[7:0], start}; bit 0 goes out first.
  function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic pflip,
                                           input logic stopb);
    return {stopb, (~^b) ^ pflip, b, 1'b0};
  endfunction

  // Drive one frame; rst_bit >= 0 pulses reset just before that bit.
  task automatic send(input int which, input logic [10:0] fr, input int half,
                      input int rst_bit);
    for (int i = 0; i < 11; i++) begin
      if (i == rst_bit) begin
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("rst_mid_outputs", {sc1, kv1, kb1, ke1, fe1}, 0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
      end
      @(negedge clock);
      if (which == 1) d1 = fr[i]; else d2 = fr[i];
      repeat (half) @(negedge clock);
      if (which == 1) c1 = 1'b0; else c2 = 1'b0;
      repeat (half) @(negedge clock);
      if (which == 1) c1 = 1'b1; else c2 = 1'b1;
    end
    if (which == 1) d1 = 1'b1; else d2 = 1'b1;
    repeat (40) @(negedge clock);
  endtask

  typedef struct {
    logic [7:0] b;
    logic       pflip;
    logic       stopb;
    int         half;
    int         exp_kv;
    int         exp_fe;
    logic [7:0] exp_sc;
    logic       exp_kb;
    logic       exp_ke;
  } vec_t;

  vec_t vt[16];

  initial begin
    int k0, f0, lat;
    logic [10:0] fr;

    //        byte   pfl   stop  half  kv fe  sc     kb    ke
    vt[0]  = '{8'h1C, 1'b0, 1'b1, 1000, 1, 0, 8'h1C, 1'b0, 1'b0};
    vt[1]  = '{8'hF0, 1'b0, 1'b1,   60, 0, 0, 8'h1C, 1'b0, 1'b0};
    vt[2]  = '{8'h1C, 1'b0, 1'b1,   60, 1, 0, 8'h1C, 1'b1, 1'b0};
    vt[3]  = '{8'h1C, 1'b0, 1'b1,   60, 1, 0, 8'h1C, 1'b0, 1'b0};
    vt[4]  = '{8'hE0, 1'b0, 1'b1,   60, 0, 0, 8'h1C, 1'b0, 1'b0};
    vt[5]  = '{8'hF0, 1'b0, 1'b1,   60, 0, 0, 8'h1C, 1'b0, 1'b0};
    vt[6]  = '{8'h75, 1'b0, 1'b1,   60, 1, 0, 8'h75, 1'b1, 1'b1};
    vt[7]  = '{8'hF0, 1'b0, 1'b1,   60, 0, 0, 8'h75, 1'b1, 1'b1};
    vt[8]  = '{8'hF0, 1'b0, 1'b1,   60, 0, 0, 8'h75, 1'b1, 1'b1};
    vt[9]  = '{8'hE0, 1'b0, 1'b1,   60, 0, 0, 8'h75, 1'b1, 1'b1};
    vt[10] = '{8'hE0, 1'b0, 1'b1,   60, 0, 0, 8'h75, 1'b1, 1'b1};
    vt[11] = '{8'h12, 1'b0, 1'b1,   60, 1, 0, 8'h12, 1'b1, 1'b1};
    vt[12] = '{8'h1C, 1'b1, 1'b1,   60, 0, 1, 8'h12, 1'b1, 1'b1};
    vt[13] = '{8'hF0, 1'b0, 1'b1,   60, 0, 0, 8'h12, 1'b1, 1'b1};
    vt[14] = '{8'h1C, 1'b0, 1'b0,   60, 0, 1, 8'h12, 1'b1, 1'b1};
    vt[15] = '{8'h1C, 1'b0, 1'b1,   60, 1, 0, 8'h1C, 1'b0, 1'b0};

    // Reset state of both instances.
    #3 reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("reset_dut", {sc1, kv1, kb1, ke1, fe1}, 0);
    chk("reset_dut_to", {sc2, kv2, kb2, ke2, fe2}, 0);
    reset = 1'b1;
    repeat (10) @(negedge clock);

    // Frame table.
    for (int i = 0; i < 16; i++) begin
      k0 = kvc1;
      f0 = fec1;
      send(1, mk_frame(vt[i].b, vt[i].pflip, vt[i].stopb), vt[i].half, -1);
      chk($sformatf("v%0d_keyValid_cnt", i), kvc1 - k0, vt[i].exp_kv);
      chk($sformatf("v%0d_frameErr_cnt", i), fec1 - f0, vt[i].exp_fe);
      chk($sformatf("v%0d_scanCode", i), sc1, vt[i].exp_sc);
      chk($sformatf("v%0d_keyBreak", i), kb1, vt[i].exp_kb);
      chk($sformatf("v%0d_keyExt", i), ke1, vt[i].exp_ke);
    end
    chk("valid_err_overlap", both1, 0);

    // Timeout: start + 4 data bits, then clock parked high.
    fr = mk_frame(8'h1C, 1'b0, 1'b1);
    f0 = fec2;
    k0 = kvc2;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      d2 = fr[i];
      repeat (60) @(negedge clock);
      c2 = 1'b0;
      if (i < 4) begin
        repeat (60) @(negedge clock);
        c2 = 1'b1;
      end
    end
    d2 = 1'b1;
    lat = -1;
    for (int k = 1; k <= 800; k++) begin
      @(negedge clock);
      if (k == 60) c2 = 1'b1;
      if (fe2 && lat < 0) lat = k - 1;
    end
    // Pin fall to sample event is 2+FILTER_LEN, then TIMEOUT_CYCLES more.
    chk("timeout_latency", lat, 2 + 4 + 500);
    chk("timeout_err_cnt", fec2 - f0, 1);
    chk("timeout_no_valid", kvc2 - k0, 0);
    send(2, mk_frame(8'h1C, 1'b0, 1'b1), 60, -1);
    chk("post_timeout_valid", kvc2 - k0, 1);
    chk("post_timeout_code", sc2, 8'h1C);
    chk("post_timeout_flags", {kb2, ke2}, 0);
    chk("post_timeout_err", fec2 - f0, 1);

    // Glitches shorter than the filter, with data low so a false start would show.
    k0 = kvc1;
    f0 = fec1;
    d1 = 1'b0;
    for (int g = 0; g < 6; g++) begin
      @(negedge clock);
      c1 = 1'b0;
      repeat ((g < 3) ? 2 : 3) @(negedge clock);
      c1 = 1'b1;
      repeat (10) @(negedge clock);
    end
    d1 = 1'b1;
    repeat (20) @(negedge clock);
    chk("glitch_no_valid", kvc1 - k0, 0);
    chk("glitch_no_err", fec1 - f0, 0);
    send(1, mk_frame(8'h29, 1'b0, 1'b1), 60, -1);
    chk("glitch_then_frame_valid", kvc1 - k0, 1);
    chk("glitch_then_frame_err", fec1 - f0, 0);
    chk("glitch_then_frame_code", sc1, 8'h29);

    // Reset mid-frame of an F0; remaining bits are all ones so IDLE ignores them.
    k0 = kvc1;
    f0 = fec1;
    send(1, mk_frame(8'hF0, 1'b0, 1'b1), 60, 5);
    chk("rst_frame_no_valid", kvc1 - k0, 0);
    chk("rst_frame_no_err", fec1 - f0, 0);
    send(1, mk_frame(8'h1C, 1'b0, 1'b1), 60, -1);
    chk("rst_next_valid", kvc1 - k0, 1);
    chk("rst_next_code", sc1, 8'h1C);
    chk("rst_next_break", kb1, 0);
    chk("final_overlap", both1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
